title_pixel_pipe: RTL and testbench
===================================

// Module: title_pixel_pipe
// PURPOSE
//  Downstream of the title-overlay locator; consumes its per-pixel is_obj/Obj_address/Game_Start_On.
//  Fetches the palette index from the synchronous title-sprite ROM and maps it through a 16-entry palette.
//  Applies a press-start blink and a post-start fade-out, then delivers pixel-aligned RGB plus a hit flag to the colour mapper.
// PARAMETERS
//  ADDR_W       18  sprite ROM address width (matches Obj_address)
//  IDX_W        4   palette index width; index 0 = transparent
//  BLINK_FRAMES 30  frame_ticks per blink half-period (SHOW or HIDE)
//  FADE_FRAMES  8   frame_ticks per fade step
//  FADE_STEPS   4   fade steps before OFF (brightness >> step, 1..FADE_STEPS)
// PORTS
//  Clk            in   1       system clock
//  Reset          in   1       asynchronous, active-low reset
//  pix_valid      in   1       pixel strobe; qualifies is_obj/Obj_address this cycle
//  is_obj         in   1       pixel inside title box
//  Obj_address    in   ADDR_W  sprite ROM address for this pixel
//  Game_Start_On  in   1       title screen active
//  frame_tick     in   1       one-cycle pulse at start of each frame
//  rom_addr       out  ADDR_W  ROM read address (registered)
//  rom_data       in   IDX_W   ROM palette index, valid 1 cycle after rom_addr
//  out_valid      out  1       RGB/out_is_obj valid
//  out_is_obj     out  1       opaque, visible title pixel
//  out_r,out_g,out_b out 8     pixel colour; 0 when out_is_obj=0
// BEHAVIOUR
//  Reset (async, Reset=0): rom_addr=0, out_valid=0, out_is_obj=0, RGB=0, all pipe valids=0, FSM=SHOW, counters=0.
//  Pipeline (free-running, 1 stage/cycle), total latency 3 cycles from pix_valid to out_valid:
//   S0: register pix_valid, is_obj, Obj_address->rom_addr. S1: ROM returns index; carry valid/is_obj.
//   S2: palette lookup, transparency, blink/fade gating; registered outputs.
//  Back-to-back pix_valid gives one output per cycle; gaps propagate as out_valid=0.
//  out_is_obj = valid & is_obj & (index!=0) & (FSM in SHOW or FADE). Otherwise out_is_obj=0, RGB=0.
//  Fade colour: each channel >> fade_step (logical shift, 8-bit, no rounding).
//  FSM states: SHOW, HIDE, FADE, OFF.
//   SHOW/HIDE: frame counter++ on frame_tick; at BLINK_FRAMES toggle SHOW<->HIDE, counter cleared.
//   SHOW/HIDE and Game_Start_On==0: ->FADE, fade_step=1, counter cleared. This takes priority over a simultaneous frame_tick.
//   FADE: counter++ on frame_tick; at FADE_FRAMES fade_step++, counter cleared.
//         Step increment past FADE_STEPS ->OFF.
//   OFF: output suppressed. Game_Start_On==1 ->SHOW, counters cleared.
//   FADE and Game_Start_On returns to 1 ->SHOW, fade_step=0.
//  FSM state is sampled at S2, so a state change affects pixels leaving S2 from the next cycle on.
//   No pipeline flush.
//  Counters are wide enough for max(BLINK_FRAMES,FADE_FRAMES) and never wrap silently.
//  Reset mid-frame: in-flight pixels are discarded (valids cleared); outputs 0 until new pix_valid + 3 cycles.
// CONFIGURATION
//  TITLE_BLINK_EN defined: SHOW/HIDE blink as above.
//  Not defined: FSM never enters HIDE, title shown steadily while Game_Start_On=1; FADE/OFF unchanged.
// STRUCTURE
//  Shared package title_pkg: enum title_state_t {SHOW,HIDE,FADE,OFF}; typedef rgb_t struct {r,g,b 8b};
//   localparam IDX_TRANSPARENT=0.
//  Sub-module title_palette: combinational IDX_W->rgb_t 16-entry LUT (entry 0 = black, unused).
//  Top holds pipe regs, FSM, counters, fade shifter.
// TESTING
//  Reset low mid-stream with pix_valid=1 -> out_valid/out_is_obj/RGB=0 immediately.
//   First out_valid 3 cycles after the first post-reset pix_valid.
//  pix_valid=1, is_obj=1, Obj_address=0x00123, rom_data=5 (palette FF,80,00), SHOW -> rom_addr=0x00123 next cycle.
//   out_is_obj=1, RGB=FF/80/00 at cycle+3.
//  Same pixel with rom_data=0 -> out_valid=1, out_is_obj=0, RGB=0.
//  TITLE_BLINK_EN on, BLINK_FRAMES=2 -> after 2 frame_ticks opaque pixels give out_is_obj=0 (HIDE).
//   After 2 more ticks they give 1 again. Macro off -> always 1.
//  Drop Game_Start_On in the same cycle as a frame_tick -> FADE, step1: FF,80,00 -> 7F,40,00.
//   After FADE_FRAMES ticks step2 -> 3F,20,00; after FADE_STEPS steps -> OFF, out_is_obj=0.
//  FADE then Game_Start_On=1 -> SHOW next cycle, full-brightness colour restored.

Source files
------------

// File: rtl/title_pkg.sv
// Shared types for the title-overlay pixel pipeline: FSM states, packed RGB
// pixel, the transparent palette index and a counter sizing helper.
package title_pkg;

  typedef enum logic [1:0] {
    SHOW = 2'd0,
    HIDE = 2'd1,
    FADE = 2'd2,
    OFF  = 2'd3
  } title_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int IDX_TRANSPARENT = 0;

  // Bits needed to hold any value 0..max(a,b) without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/title_pixel_pipe_if.sv
// Pixel/ROM/colour-mapper bundle for title_pixel_pipe. The master side is the
// environment (locator, sprite ROM, frame timing); the slave side is the pipe.
interface title_pixel_pipe_if #(
  parameter int ADDR_W = 18,
  parameter int IDX_W  = 4
);
  logic              pix_valid;
  logic              is_obj;
  logic [ADDR_W-1:0] Obj_address;
  logic              Game_Start_On;
  logic              frame_tick;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data;
  logic              out_valid;
  logic              out_is_obj;
  logic [7:0]        out_r;
  logic [7:0]        out_g;
  logic [7:0]        out_b;

  modport master (
    output pix_valid, is_obj, Obj_address, Game_Start_On, frame_tick, rom_data,
    input  rom_addr, out_valid, out_is_obj, out_r, out_g, out_b
  );

  modport slave (
    input  pix_valid, is_obj, Obj_address, Game_Start_On, frame_tick, rom_data,
    output rom_addr, out_valid, out_is_obj, out_r, out_g, out_b
  );
endinterface

// File: rtl/title_palette.sv
// 16-entry combinational palette for the title sprite. Entry 0 is the
// transparent index and is never displayed; it is kept black.
module title_palette
  import title_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output rgb_t             rgb_o
);

  localparam rgb_t LUT [16] = '{
    '{8'h00, 8'h00, 8'h00},  // 0 transparent
    '{8'hFF, 8'hFF, 8'hFF},  // 1 white
    '{8'hFF, 8'h00, 8'h00},  // 2 red
    '{8'h00, 8'hFF, 8'h00},  // 3 green
    '{8'h00, 8'h00, 8'hFF},  // 4 blue
    '{8'hFF, 8'h80, 8'h00},  // 5 orange
    '{8'hFF, 8'hFF, 8'h00},  // 6 yellow
    '{8'h00, 8'hFF, 8'hFF},  // 7 cyan
    '{8'hFF, 8'h00, 8'hFF},  // 8 magenta
    '{8'h80, 8'h80, 8'h80},  // 9 grey
    '{8'hC0, 8'hC0, 8'hC0},  // A light grey
    '{8'h80, 8'h00, 8'h00},  // B maroon
    '{8'h00, 8'h80, 8'h00},  // C dark green
    '{8'h00, 8'h00, 8'h80},  // D navy
    '{8'h80, 8'h40, 8'h00},  // E brown
    '{8'h20, 8'h20, 8'h20}   // F near black
  };

  // Pure table lookup, no state.
  always_comb begin
    rgb_o = LUT[idx_i];
  end

endmodule

// File: rtl/title_pixel_pipe.sv
// Title-overlay pixel pipeline: registers the locator's pixel into the sprite
// ROM address, carries it across the ROM read, then maps the palette index to
// RGB with press-start blink and post-start fade gating. 3-cycle latency.
// Build option: define TITLE_BLINK_EN to enable the SHOW/HIDE blink; without
// it the title is shown steadily while Game_Start_On is high.
module title_pixel_pipe
  import title_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int FADE_FRAMES  = 8,
  parameter int FADE_STEPS   = 4
) (
  input logic               Clk,
  input logic               Reset,
  title_pixel_pipe_if.slave bus
);

  localparam int CNT_W  = cnt_width(BLINK_FRAMES, FADE_FRAMES);
  localparam int STEP_W = cnt_width(FADE_STEPS, 1);

  // Logical right shift of one 8-bit channel; steps past 7 give black.
  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [STEP_W-1:0] s);
    return c >> s;
  endfunction

  logic              vld_p0, obj_p0;
  logic              vld_p1, obj_p1;
  logic [ADDR_W-1:0] rom_addr_q;

  title_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [STEP_W-1:0] step_q, step_d, step_inc;

  rgb_t              pal_rgb;
  logic              hit_d, out_valid_q, out_is_obj_q;
  rgb_t              rgb_d, rgb_q;
  logic              visible;
  logic [STEP_W-1:0] shift;

  title_palette #(.IDX_W(IDX_W)) u_palette (
    .idx_i (bus.rom_data),
    .rgb_o (pal_rgb)
  );

  // ---- S0/S1: capture pixel, drive ROM address, carry across ROM read ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_p0     <= 1'b0;
      obj_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      obj_p1     <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      vld_p0     <= bus.pix_valid;
      obj_p0     <= bus.is_obj;
      rom_addr_q <= bus.Obj_address;
      vld_p1     <= vld_p0;
      obj_p1     <= obj_p0;
    end
  end

  // Blink/fade FSM state, frame counter and fade step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= SHOW;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic; leaving the title (Game_Start_On low) beats any frame_tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    step_inc = step_q + STEP_W'(1);
    case (state_q)
      SHOW, HIDE: begin
        if (!bus.Game_Start_On) begin
          state_d = FADE;
          step_d  = STEP_W'(1);
          cnt_d   = '0;
        end
`ifdef TITLE_BLINK_EN
        else if (bus.frame_tick) begin
          if (cnt_inc == CNT_W'(BLINK_FRAMES)) begin
            state_d = (state_q == SHOW) ? HIDE : SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`else
        else begin
          state_d = SHOW;
          cnt_d   = '0;
        end
`endif
      end
      FADE: begin
        if (bus.Game_Start_On) begin
          state_d = SHOW;
          step_d  = '0;
          cnt_d   = '0;
        end else if (bus.frame_tick) begin
          if (cnt_inc == CNT_W'(FADE_FRAMES)) begin
            cnt_d = '0;
            if (step_q == STEP_W'(FADE_STEPS)) begin
              state_d = OFF;
              step_d  = '0;
            end else begin
              step_d = step_inc;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      OFF: begin
        if (bus.Game_Start_On) begin
          state_d = SHOW;
          cnt_d   = '0;
          step_d  = '0;
        end
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
        step_d  = '0;
      end
    endcase
  end

  // S2 combinational: transparency and blink/fade gating of the palette colour.
  always_comb begin
    visible = (state_q == SHOW) || (state_q == FADE);
    shift   = (state_q == FADE) ? step_q : '0;
    hit_d   = vld_p1 && obj_p1 && visible &&
              (bus.rom_data != IDX_W'(IDX_TRANSPARENT));
    rgb_d   = '0;
    if (hit_d) begin
      rgb_d.r = fade_ch(pal_rgb.r, shift);
      rgb_d.g = fade_ch(pal_rgb.g, shift);
      rgb_d.b = fade_ch(pal_rgb.b, shift);
    end
  end

  // ---- S2: registered outputs to the colour mapper ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid_q  <= 1'b0;
      out_is_obj_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      out_valid_q  <= vld_p1;
      out_is_obj_q <= hit_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_is_obj = out_is_obj_q;
  assign bus.out_r      = rgb_q.r;
  assign bus.out_g      = rgb_q.g;
  assign bus.out_b      = rgb_q.b;

endmodule

// File: tb/tb_title_pixel_pipe.sv
// Directed bench for title_pixel_pipe: reset, latency, palette/transparency,
// back-to-back pixels, blink, mid-stream reset, fade steps, OFF and restart.
module tb_title_pixel_pipe;
  import title_pkg::*;

  localparam int AW = 18;
  localparam int IW = 4;
`ifdef TITLE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  title_pixel_pipe_if #(.ADDR_W(AW), .IDX_W(IW)) bus ();

  title_pixel_pipe #(
    .ADDR_W(AW), .IDX_W(IW), .BLINK_FRAMES(2), .FADE_FRAMES(8), .FADE_STEPS(4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous sprite ROM model: only address 0x00123 holds a non-zero index.
  logic [IW-1:0] rom_val;
  always @(posedge Clk) bus.rom_data <= (bus.rom_addr == 18'h00123) ? rom_val : 4'd0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb_now();
    return {8'h00, bus.out_r, bus.out_g, bus.out_b};
  endfunction

  // Present one pixel, then follow it through the three pipeline stages.
  task automatic pixel_check(input string tag, input logic obj, input logic [IW-1:0] idx,
                             input logic exp_hit, input logic [23:0] exp_rgb);
    @(negedge Clk);
    rom_val         = idx;
    bus.pix_valid   = 1'b1;
    bus.is_obj      = obj;
    bus.Obj_address = 18'h00123;
    @(negedge Clk);
    bus.pix_valid   = 1'b0;
    bus.is_obj      = 1'b0;
    bus.Obj_address = 18'h00000;
    check({tag, "_romaddr"}, 32'(bus.rom_addr), 32'h00123);
    check({tag, "_vld_c1"}, 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check({tag, "_vld_c2"}, 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_hit"}, 32'(bus.out_is_obj), 32'(exp_hit));
    check({tag, "_rgb"}, rgb_now(), {8'h00, exp_rgb});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      bus.frame_tick = 1'b1;
      @(negedge Clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  initial begin
    bus.pix_valid     = 1'b0;
    bus.is_obj        = 1'b0;
    bus.Obj_address   = '0;
    bus.Game_Start_On = 1'b1;
    bus.frame_tick    = 1'b0;
    rom_val           = '0;

    repeat (3) @(negedge Clk);
    check("rst_vld", 32'(bus.out_valid), 32'd0);
    check("rst_hit", 32'(bus.out_is_obj), 32'd0);
    check("rst_rgb", rgb_now(), 32'd0);
    check("rst_romaddr", 32'(bus.rom_addr), 32'd0);
    Reset = 1'b1;

    pixel_check("basic", 1'b1, 4'd5, 1'b1, 24'hFF8000);
    pixel_check("transp", 1'b1, 4'd0, 1'b0, 24'h000000);
    pixel_check("notobj", 1'b0, 4'd5, 1'b0, 24'h000000);
    pixel_check("idx2", 1'b1, 4'd2, 1'b1, 24'hFF0000);

    // Two back-to-back pixels then a gap.
    @(negedge Clk);
    rom_val = 4'd5; bus.pix_valid = 1'b1; bus.is_obj = 1'b1; bus.Obj_address = 18'h00123;
    @(negedge Clk);
    @(negedge Clk);
    bus.pix_valid = 1'b0;
    @(negedge Clk);
    check("b2b_vld0", 32'(bus.out_valid), 32'd1);
    @(negedge Clk);
    check("b2b_vld1", 32'(bus.out_valid), 32'd1);
    check("b2b_rgb1", rgb_now(), 32'h00FF8000);
    @(negedge Clk);
    check("b2b_gap", 32'(bus.out_valid), 32'd0);

    // Blink: two ticks reach HIDE when enabled, two more return to SHOW.
    ticks(2);
    pixel_check("blink_a", 1'b1, 4'd5, !BLINK, BLINK ? 24'h000000 : 24'hFF8000);
    ticks(2);
    pixel_check("blink_b", 1'b1, 4'd5, 1'b1, 24'hFF8000);

    // Reset in the middle of a pixel stream.
    @(negedge Clk);
    rom_val = 4'd5; bus.pix_valid = 1'b1; bus.is_obj = 1'b1; bus.Obj_address = 18'h00123;
    repeat (4) @(negedge Clk);
    check("prerst_hit", 32'(bus.out_is_obj), 32'd1);
    Reset = 1'b0;
    #1;
    check("midrst_vld", 32'(bus.out_valid), 32'd0);
    check("midrst_hit", 32'(bus.out_is_obj), 32'd0);
    check("midrst_rgb", rgb_now(), 32'd0);
    check("midrst_romaddr", 32'(bus.rom_addr), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("postrst_c1", 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check("postrst_c2", 32'(bus.out_valid), 32'd0);
    @(negedge Clk);
    check("postrst_c3_vld", 32'(bus.out_valid), 32'd1);
    check("postrst_c3_rgb", rgb_now(), 32'h00FF8000);
    bus.pix_valid = 1'b0;
    repeat (3) @(negedge Clk);

    // Fade entered on the same cycle as a frame_tick.
    @(negedge Clk);
    bus.Game_Start_On = 1'b0;
    bus.frame_tick    = 1'b1;
    @(negedge Clk);
    bus.frame_tick    = 1'b0;
    pixel_check("fade1", 1'b1, 4'd5, 1'b1, 24'h7F4000);
    ticks(8);
    pixel_check("fade2", 1'b1, 4'd5, 1'b1, 24'h3F2000);
    ticks(16);
    pixel_check("fade4", 1'b1, 4'd5, 1'b1, 24'h0F0800);
    ticks(8);
    pixel_check("off", 1'b1, 4'd5, 1'b0, 24'h000000);

    // OFF -> SHOW on restart.
    @(negedge Clk);
    bus.Game_Start_On = 1'b1;
    pixel_check("restart", 1'b1, 4'd5, 1'b1, 24'hFF8000);

    // FADE aborted by Game_Start_On returning.
    @(negedge Clk);
    bus.Game_Start_On = 1'b0;
    pixel_check("fade_again", 1'b1, 4'd5, 1'b1, 24'h7F4000);
    @(negedge Clk);
    bus.Game_Start_On = 1'b1;
    pixel_check("fade_abort", 1'b1, 4'd5, 1'b1, 24'hFF8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
